key_pulse_gen: RTL and testbench
================================

// Module: key_pulse_gen
// PURPOSE
//  Front end for the vision-test panel's push buttons. Takes six raw mechanical key inputs
//  (restart, left, right, up, down, eye-change), then synchronises and debounces each one.
//  Emits exactly one single-cycle clk pulse per confirmed press, the form the display-state
//  FSM consumes. Direction pulses are one-hot per cycle.
// PARAMETERS
//  DEB_CYCLES    1000000  stable-level cycles required to accept a new key level (20 ms @ 50 MHz); >=2
//  CNT_W         20       debounce counter width; 2**CNT_W >= DEB_CYCLES
//  ACTIVE_LEVEL  1'b1     raw level meaning "pressed" (0 for active-low keys)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  reset
//  key_raw        in   6  raw keys {change,down,up,right,left,restart} = bits [5:0]
//  restart_pulse  out  1  one-cycle pulse, restart press
//  left_pulse     out  1  one-cycle pulse, left press
//  right_pulse    out  1  one-cycle pulse, right press
//  up_pulse       out  1  one-cycle pulse, up press
//  down_pulse     out  1  one-cycle pulse, down press
//  change_pulse   out  1  one-cycle pulse, eye-change press
//  key_level      out  6  debounced level per key, 1 = pressed (after polarity fix)
// BEHAVIOUR
//  - Reset rst, asynchronous, active-high; clock clk. All logic on posedge clk.
//  - Reset state:
//    - all pulses 0; key_level 0; per-key counters 0; FSMs in IDLE.
//    - sync flops = released level (~ACTIVE_LEVEL).
//  - Per key, 2-FF synchroniser. Polarity is normalised so that 1 = pressed.
//  - Per-key debounce counter:
//    - counts while the sync output != key_level; clears to 0 on any cycle where they are equal.
//    - when the count reaches DEB_CYCLES-1 on a mismatch cycle, key_level flips at that edge
//      and the counter clears. The count never exceeds DEB_CYCLES-1.
//  - Per-key FSM, two states:
//    - IDLE -> PRESSED when key_level rises; the raw pulse is registered high for exactly 1 cycle.
//    - PRESSED -> IDLE when key_level falls; no pulse on release.
//    - No auto-repeat while held.
//  - Latency: if key_raw changes and stays stable, the pulse goes high on rising edge
//    DEB_CYCLES+3, counting from the first edge that samples the new raw level.
//  - Bounce: a level held for fewer than DEB_CYCLES sync cycles is discarded, giving no pulse
//    and no key_level change.
//  - Direction arbitration (left/right/up/down), on raw pulses in the same cycle:
//    - priority left > right > up > down; only the winner's pulse is output, losers are dropped.
//    - restart and change are independent of the arbiter and of each other.
//  - A key held through reset deassertion is treated as a new press: one pulse after full
//    debounce latency.
//  - Reset asserted mid-debounce or mid-pulse aborts immediately; no partial pulse follows.
//  - Outputs are registered; no combinational path from key_raw to any output.
// TESTING  (bench uses DEB_CYCLES=4, CNT_W=3, ACTIVE_LEVEL=1)
//  1. left raw 0->1 held 20 cycles -> left_pulse high exactly 1 cycle at edge 7; key_level[1]=1
//     from edge 6; no other pulse.
//  2. up raw pulses 1 for 3 cycles then 0 (bounce) -> no up_pulse; key_level[3] stays 0.
//  3. right and down raw rise on the same edge, held 10 cycles -> right_pulse once, down_pulse
//     never; key_level[2] and key_level[4] both 1.
//  4. restart held 50 cycles, released, pressed again -> exactly two restart_pulse, second at
//     edge 7 of the second press; no pulse on release.
//  5. change raw=1 during rst, rst released at edge 0 -> change_pulse at edge 7.
//  6. rst asserted at edge 5 of a left press, released at edge 8 with left still held ->
//     no pulse before edge 8; one left_pulse at edge 15.

Source files
------------

// File: rtl/key_pulse_gen.sv
// Push-button front end: per-key synchroniser, debouncer and press detector, emitting one
// single-cycle pulse per confirmed press with left > right > up > down arbitration.
module key_pulse_gen #(
  parameter int unsigned DEB_CYCLES   = 1000000,
  parameter int unsigned CNT_W        = 20,
  parameter logic        ACTIVE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] key_raw,
  output logic       restart_pulse,
  output logic       left_pulse,
  output logic       right_pulse,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       change_pulse,
  output logic [5:0] key_level
);

  localparam int unsigned      NumKeys   = 6;
  localparam logic [CNT_W-1:0] CntMax    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [5:0]       RelLevel  = {6{~ACTIVE_LEVEL}};
  localparam logic             StIdle    = 1'b0;
  localparam logic             StPressed = 1'b1;

  logic [5:0]       sync1_q, sync2_q;
  logic [5:0]       pressed;
  logic [CNT_W-1:0] cnt_q [NumKeys];
  logic [CNT_W-1:0] cnt_d [NumKeys];
  logic [5:0]       level_q, level_d;
  logic [5:0]       state_q, state_d;
  logic [5:0]       rise;
  logic [5:0]       pulse_q, pulse_d;

  // Normalise polarity so that 1 always means pressed.
  assign pressed = sync2_q ^ RelLevel;

  always_comb begin
    level_d = level_q;
    state_d = state_q;
    rise    = '0;
    for (int k = 0; k < NumKeys; k++) begin
      cnt_d[k] = '0;
      if (pressed[k] != level_q[k]) begin
        if (cnt_q[k] == CntMax) begin
          level_d[k] = ~level_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end

      case (state_q[k])
        StIdle: begin
          if (level_q[k]) begin
            state_d[k] = StPressed;
            rise[k]    = 1'b1;
          end
        end
        default: begin
          if (!level_q[k]) begin
            state_d[k] = StIdle;
          end
        end
      endcase
    end
  end

  // Restart and change bypass the direction arbiter.
  always_comb begin
    pulse_d    = '0;
    pulse_d[0] = rise[0];
    pulse_d[5] = rise[5];
    pulse_d[1] = rise[1];
    pulse_d[2] = rise[2] & ~rise[1];
    pulse_d[3] = rise[3] & ~|rise[2:1];
    pulse_d[4] = rise[4] & ~|rise[3:1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RelLevel;
      sync2_q <= RelLevel;
      level_q <= '0;
      state_q <= {6{StIdle}};
      pulse_q <= '0;
      for (int k = 0; k < NumKeys; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      state_q <= state_d;
      pulse_q <= pulse_d;
      for (int k = 0; k < NumKeys; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign restart_pulse = pulse_q[0];
  assign left_pulse    = pulse_q[1];
  assign right_pulse   = pulse_q[2];
  assign up_pulse      = pulse_q[3];
  assign down_pulse    = pulse_q[4];
  assign change_pulse  = pulse_q[5];
  assign key_level     = level_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: cycle-by-cycle comparison against a behavioural key model plus
// directed scenarios with hand-computed pulse edges.
module tb_key_pulse_gen;

  localparam int Deb = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] key_raw;
  logic       restart_pulse, left_pulse, right_pulse, up_pulse, down_pulse, change_pulse;
  logic [5:0] key_level;

  key_pulse_gen #(
    .DEB_CYCLES  (Deb),
    .CNT_W       (3),
    .ACTIVE_LEVEL(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_raw      (key_raw),
    .restart_pulse(restart_pulse),
    .left_pulse   (left_pulse),
    .right_pulse  (right_pulse),
    .up_pulse     (up_pulse),
    .down_pulse   (down_pulse),
    .change_pulse (change_pulse),
    .key_level    (key_level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int pcnt   [6];
  int plast  [6];
  int lfirst [6];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 6; k++) begin
      pcnt[k]   = 0;
      plast[k]  = -1;
      lfirst[k] = -1;
    end
  endtask

  // Model: raw seen two edges late; level flips after Deb consecutive disagreeing samples;
  // a press pulse appears the edge after the level rises, directions arbitrated by priority.
  logic [5:0] m_s1, m_s2, m_lvl, m_lvl_prev, m_pulse, rises, act_p;
  int         m_run [6];

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_prev = '0; m_pulse = '0;
      for (int k = 0; k < 6; k++) m_run[k] = 0;
    end else begin
      rises   = m_lvl & ~m_lvl_prev;
      m_pulse = rises & 6'b100001;
      for (int k = 1; k <= 4; k++) begin
        if (rises[k]) begin
          m_pulse[k] = 1'b1;
          break;
        end
      end
      m_lvl_prev = m_lvl;
      for (int k = 0; k < 6; k++) begin
        if (m_s2[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == Deb) begin
            m_lvl[k] = ~m_lvl[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = key_raw;
    end
    cyc++;
    #1;
    act_p = {change_pulse, down_pulse, up_pulse, right_pulse, left_pulse, restart_pulse};
    chk("pulses", int'(act_p), int'(m_pulse));
    chk("key_level", int'(key_level), int'(m_lvl));
    for (int k = 0; k < 6; k++) begin
      if (act_p[k]) begin
        pcnt[k]++;
        plast[k] = cyc;
      end
      if (key_level[k] && lfirst[k] < 0) lfirst[k] = cyc;
    end
  end

  int base;
  int others;

  initial begin
    clear_logs();
    rst     = 1'b1;
    key_raw = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: left press, pulse at edge 7, level from edge 6
    clear_logs();
    key_raw[1] = 1'b1;
    base = cyc;
    repeat (20) @(negedge clk);
    chk("t1_left_count", pcnt[1], 1);
    chk("t1_left_edge", plast[1] - base, 7);
    chk("t1_level_edge", lfirst[1] - base, 6);
    others = pcnt[0] + pcnt[2] + pcnt[3] + pcnt[4] + pcnt[5];
    chk("t1_other_pulses", others, 0);
    key_raw[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("t1_no_release_pulse", pcnt[1], 1);

    // 2: up bounce of 3 cycles is discarded
    clear_logs();
    key_raw[3] = 1'b1;
    repeat (3) @(negedge clk);
    key_raw[3] = 1'b0;
    repeat (12) @(negedge clk);
    chk("t2_up_count", pcnt[3], 0);
    chk("t2_up_level_seen", lfirst[3], -1);

    // 3: right and down together, right wins
    clear_logs();
    key_raw[2] = 1'b1;
    key_raw[4] = 1'b1;
    base = cyc;
    repeat (10) @(negedge clk);
    chk("t3_right_count", pcnt[2], 1);
    chk("t3_right_edge", plast[2] - base, 7);
    chk("t3_down_count", pcnt[4], 0);
    chk("t3_level_right", int'(key_level[2]), 1);
    chk("t3_level_down", int'(key_level[4]), 1);
    key_raw[2] = 1'b0;
    key_raw[4] = 1'b0;
    repeat (10) @(negedge clk);

    // 4: restart held, released, pressed again
    clear_logs();
    key_raw[0] = 1'b1;
    repeat (50) @(negedge clk);
    key_raw[0] = 1'b0;
    repeat (15) @(negedge clk);
    chk("t4_after_release", pcnt[0], 1);
    key_raw[0] = 1'b1;
    base = cyc;
    repeat (20) @(negedge clk);
    chk("t4_restart_count", pcnt[0], 2);
    chk("t4_second_edge", plast[0] - base, 7);
    key_raw[0] = 1'b0;
    repeat (10) @(negedge clk);

    // 5: change held through reset release
    key_raw[5] = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    clear_logs();
    rst  = 1'b0;
    base = cyc;
    repeat (15) @(negedge clk);
    chk("t5_change_count", pcnt[5], 1);
    chk("t5_change_edge", plast[5] - base, 7);
    key_raw[5] = 1'b0;
    repeat (10) @(negedge clk);

    // 6: reset mid-debounce of a left press, key still held afterwards
    clear_logs();
    key_raw[1] = 1'b1;
    base = cyc;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_left_count", pcnt[1], 1);
    chk("t6_left_edge", plast[1] - base, 15);
    key_raw[1] = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
